magia_tile_run_ctrl: RTL and testbench
======================================

Name: magia_tile_run_ctrl

Overview:
- Sequences a single MAGIA tile run: holds the core in fetch-disable through a configurable init window, then asserts fetch_enable.
- Passively sniffs the tile's AXI write channels toward L2 and pairs each AW address with its W data beats. It decodes stdout and stderr print writes and the end-of-computation (EOC) write.
- Ends the run on EOC or on timeout.
- Sits between the tile's data_out AXI port and the L2 memory model in the tile testbench. It never drives or stalls AXI signals.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width (multiple of 8)
AW_FIFO_DEPTH, 4, outstanding AW addresses tracked (power of 2, >=2)
INIT_CYCLES, 200, cycles between start and fetch_enable assertion (>=1)
TIMEOUT_CYCLES, 0, RUN-state cycle limit; 0 disables the timeout
STDERR_ADDR, 32'hFFFF0000, error-report address
STDOUT_ADDR, 32'hFFFF0004, character-print address
EOC_ADDR, 32'hCC030000, exit-code address

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
start_i  in  1  pulse; begins a run from IDLE
boot_addr_i  in  32  entry address, latched on start
boot_addr_o  out  32  boot address to tile
fetch_enable_o  out  1  core fetch enable
aw_valid_i / aw_ready_i  in  1 / 1  sniffed AW handshake
aw_addr_i  in  ADDR_W  sniffed AW address
w_valid_i / w_ready_i / w_last_i  in  1 / 1 / 1  sniffed W handshake
w_data_i  in  DATA_W  sniffed W data
w_strb_i  in  DATA_W/8  sniffed W strobes
char_valid_o  out  1  one-cycle pulse: stdout character
char_data_o  out  8  character
err_valid_o  out  1  one-cycle pulse: stderr report
err_count_o  out  32  last reported error count
done_o  out  1  level: run finished (EOC or timeout)
exit_code_o  out  32  EOC data, or 32'hFFFF_FFFF on timeout
timeout_o  out  1  level: run ended by timeout
overflow_o  out  1  sticky: AW dropped because the FIFO was full
orphan_w_o  out  1  sticky: W beat with no tracked address

Behaviour:
- Reset values. Every output is reset synchronously on clk_i when rst_ni==0:
  - boot_addr_o = 0, fetch_enable_o = 0, err_count_o = 0, exit_code_o = 0.
  - All pulses and flags = 0; FIFO is emptied; FSM goes to IDLE.
- Reset mid-run behaves identically: fetch_enable_o drops on the next edge and all tracked state is discarded.
- FSM states: IDLE, INIT, RUN, DONE.
  - IDLE: on start_i, latch boot_addr_i into boot_addr_o, load the counter with INIT_CYCLES, go to INIT.
  - INIT: decrement the counter each cycle. At 1, go to RUN; fetch_enable_o becomes 1 exactly INIT_CYCLES cycles after the start edge.
  - RUN: fetch_enable_o=1. The cycle counter increments from 0.
    - EOC decode with nonzero data: go to DONE, exit_code_o = data, done_o = 1.
    - Timeout: if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, go to DONE with timeout_o=1 and exit_code_o = FFFF_FFFF.
    - EOC and timeout in the same cycle: EOC wins.
  - DONE: fetch_enable_o=0. Outputs hold until reset. start_i is ignored outside IDLE.
- AW tracking:
  - On aw_valid_i&&aw_ready_i, push aw_addr_i.
  - If the FIFO is full with no pop in the same cycle, drop the address and set overflow_o. A push and a pop in the same cycle while full is legal.
- W pairing:
  - On w_valid_i&&w_ready_i, the beat pairs with the FIFO head.
  - If the FIFO is empty but an AW handshake occurs in the same cycle, it pairs with aw_addr_i (bypass), and that address is not pushed unless w_last_i==0.
  - If the FIFO is empty and no AW handshake occurs, the beat is ignored and orphan_w_o is set.
  - A beat counter marks the first beat; only the first beat of a burst is decoded.
  - The head is popped on the w_last_i handshake.
- Decode (first beat only; address compared with its low $clog2(DATA_W/8) bits cleared):
  - STDOUT: lowest enabled strobe byte goes to char_data_o; char_valid_o pulses in the cycle after the handshake. If no strobe is set, no pulse.
  - STDERR: err_count_o = w_data_i[31:0]; err_valid_o pulses in the next cycle.
  - EOC: w_data_i[31:0] is used (RUN only).
  - Decodes are active in INIT and RUN only; ignored in IDLE and DONE.
- Latency: every decode output is registered, one cycle after the W handshake.

Test Plan:
- Boot: start_i with boot_addr_i=1C00_0080, INIT_CYCLES=200 -> boot_addr_o=1C00_0080 next cycle; fetch_enable_o rises exactly 200 cycles after start.
- Print: AW FFFF0004, then 3 cycles later W data 0x48 strb 0001 last -> char_valid_o pulse with char_data_o=0x48. Same with strb 0100 and data 0x00410000 -> char 0x41.
- Reordering: 3 back-to-back AWs (STDOUT, 2000_0000 4-beat burst, STDERR), then W beats in order -> exactly one char pulse, no decode on burst beats, err_count_o = STDERR data.
- EOC vs timeout: TIMEOUT_CYCLES=50, EOC write of 0 then of 7 -> DONE with exit_code_o=7, fetch_enable_o=0. With no EOC -> timeout_o=1 and exit_code_o=FFFF_FFFF at RUN cycle 50.
- Boundaries: 5 AWs with no W at depth 4 -> overflow_o=1. A W with an empty FIFO and no AW -> orphan_w_o=1. AW and W in the same cycle with an empty FIFO -> decoded correctly via bypass.
- Reset mid-RUN: rst_ni low for 1 cycle -> all outputs 0 and FSM in IDLE on the next edge; a later start_i runs cleanly.

Source files
------------

// File: rtl/magia_tile_run_ctrl.sv
// Run controller for one MAGIA tile: boot sequencing, passive AXI write sniffing
// for print/EOC decode, and run termination on EOC or timeout.
module magia_tile_run_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned AW_FIFO_DEPTH  = 4,
  parameter int unsigned INIT_CYCLES    = 200,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter logic [ADDR_W-1:0] STDERR_ADDR = 32'hFFFF_0000,
  parameter logic [ADDR_W-1:0] STDOUT_ADDR = 32'hFFFF_0004,
  parameter logic [ADDR_W-1:0] EOC_ADDR    = 32'hCC03_0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [31:0]         boot_addr_i,
  output logic [31:0]         boot_addr_o,
  output logic                fetch_enable_o,
  input  logic                aw_valid_i,
  input  logic                aw_ready_i,
  input  logic [ADDR_W-1:0]   aw_addr_i,
  input  logic                w_valid_i,
  input  logic                w_ready_i,
  input  logic                w_last_i,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic [DATA_W/8-1:0] w_strb_i,
  output logic                char_valid_o,
  output logic [7:0]          char_data_o,
  output logic                err_valid_o,
  output logic [31:0]         err_count_o,
  output logic                done_o,
  output logic [31:0]         exit_code_o,
  output logic                timeout_o,
  output logic                overflow_o,
  output logic                orphan_w_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned PTR_W  = $clog2(AW_FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;

  logic [ADDR_W-1:0] fifo_mem [AW_FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              first_reg;

  logic [31:0] boot_addr_reg, err_count_reg, exit_code_reg;
  logic [7:0]  char_data_reg;
  logic        char_valid_reg, err_valid_reg, timeout_reg, overflow_reg, orphan_reg;

  logic fifo_empty, fifo_full, aw_hs, w_hs, bypass, w_paired, w_orphan;
  logic push_req, push, pop, drop;
  logic [ADDR_W-1:0] pair_addr, pair_addr_masked;
  logic dec_en, dec_stdout, dec_stderr, eoc_hit, timeout_hit;
  logic [7:0] char_sel;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == (PTR_W+1)'(AW_FIFO_DEPTH));
  assign aw_hs      = aw_valid_i && aw_ready_i;
  assign w_hs       = w_valid_i && w_ready_i;
  assign bypass     = fifo_empty && aw_hs && w_hs;
  assign w_paired   = w_hs && (!fifo_empty || aw_hs);
  assign w_orphan   = w_hs && fifo_empty && !aw_hs;

  // A bypassed single-beat write is fully consumed; a bypassed burst start
  // still needs its address as the head for the remaining beats.
  assign pop      = w_paired && w_last_i && !fifo_empty;
  assign push_req = aw_hs && !(bypass && w_last_i);
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  assign pair_addr        = fifo_empty ? aw_addr_i : fifo_mem[rd_ptr_reg];
  assign pair_addr_masked = pair_addr & ADDR_MASK;

  assign dec_en      = w_paired && first_reg && (state_reg == S_INIT || state_reg == S_RUN);
  assign dec_stdout  = dec_en && (pair_addr_masked == (STDOUT_ADDR & ADDR_MASK));
  assign dec_stderr  = dec_en && (pair_addr_masked == (STDERR_ADDR & ADDR_MASK));
  assign eoc_hit     = dec_en && (state_reg == S_RUN) &&
                       (pair_addr_masked == (EOC_ADDR & ADDR_MASK)) && (w_data_i[31:0] != 32'd0);
  assign timeout_hit = TO_EN && (state_reg == S_RUN) && (cnt_reg == TO_LAST);

  logic [7:0] data_bytes [STRB_W];
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_bytes
    assign data_bytes[gi] = w_data_i[8*gi +: 8];
  end

  // Walk from the top lane down so the lowest enabled lane wins.
  always_comb begin
    char_sel = 8'h00;
    for (int i = STRB_W - 1; i >= 0; i--) begin
      if (w_strb_i[i]) char_sel = data_bytes[i];
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          state_next = S_INIT;
          cnt_next   = 32'(INIT_CYCLES);
        end
      end
      S_INIT: begin
        if (cnt_reg == 32'd1) begin
          state_next = S_RUN;
          cnt_next   = 32'd0;
        end else begin
          cnt_next = cnt_reg - 32'd1;
        end
      end
      S_RUN: begin
        cnt_next = cnt_reg + 32'd1;
        if (eoc_hit || timeout_hit) state_next = S_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= aw_addr_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      first_reg  <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
      if (w_paired) first_reg <= w_last_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      boot_addr_reg  <= 32'd0;
      char_valid_reg <= 1'b0;
      char_data_reg  <= 8'h00;
      err_valid_reg  <= 1'b0;
      err_count_reg  <= 32'd0;
      exit_code_reg  <= 32'd0;
      timeout_reg    <= 1'b0;
      overflow_reg   <= 1'b0;
      orphan_reg     <= 1'b0;
    end else begin
      if (state_reg == S_IDLE && start_i) boot_addr_reg <= boot_addr_i;
      char_valid_reg <= dec_stdout && (|w_strb_i);
      if (dec_stdout && (|w_strb_i)) char_data_reg <= char_sel;
      err_valid_reg <= dec_stderr;
      if (dec_stderr) err_count_reg <= w_data_i[31:0];
      if (eoc_hit) begin
        exit_code_reg <= w_data_i[31:0];
      end else if (timeout_hit) begin
        exit_code_reg <= 32'hFFFF_FFFF;
        timeout_reg   <= 1'b1;
      end
      if (drop)     overflow_reg <= 1'b1;
      if (w_orphan) orphan_reg   <= 1'b1;
    end
  end

  assign boot_addr_o    = boot_addr_reg;
  assign fetch_enable_o = (state_reg == S_RUN);
  assign done_o         = (state_reg == S_DONE);
  assign char_valid_o   = char_valid_reg;
  assign char_data_o    = char_data_reg;
  assign err_valid_o    = err_valid_reg;
  assign err_count_o    = err_count_reg;
  assign exit_code_o    = exit_code_reg;
  assign timeout_o      = timeout_reg;
  assign overflow_o     = overflow_reg;
  assign orphan_w_o     = orphan_reg;

endmodule

// File: tb/tb_magia_tile_run_ctrl.sv
// Bench for magia_tile_run_ctrl: directed boot/print/EOC/timeout/boundary steps
// plus randomized sniffed writes, checked against a queue-based reference model.
module tb_magia_tile_run_ctrl;

  localparam int INIT = 200;
  localparam int TO   = 50;
  localparam int DEPTH = 4;
  localparam logic [31:0] A_ERR = 32'hFFFF_0000;
  localparam logic [31:0] A_OUT = 32'hFFFF_0004;
  localparam logic [31:0] A_EOC = 32'hCC03_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni, start_i;
  logic [31:0] boot_addr_i, boot_addr_o;
  logic        fetch_enable_o;
  logic        aw_valid_i, aw_ready_i, w_valid_i, w_ready_i, w_last_i;
  logic [31:0] aw_addr_i, w_data_i;
  logic [3:0]  w_strb_i;
  logic        char_valid_o, err_valid_o, done_o, timeout_o, overflow_o, orphan_w_o;
  logic [7:0]  char_data_o;
  logic [31:0] err_count_o, exit_code_o;

  magia_tile_run_ctrl #(
    .ADDR_W(32), .DATA_W(32), .AW_FIFO_DEPTH(DEPTH), .INIT_CYCLES(INIT),
    .TIMEOUT_CYCLES(TO), .STDERR_ADDR(A_ERR), .STDOUT_ADDR(A_OUT), .EOC_ADDR(A_EOC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .boot_addr_i(boot_addr_i), .boot_addr_o(boot_addr_o), .fetch_enable_o(fetch_enable_o),
    .aw_valid_i(aw_valid_i), .aw_ready_i(aw_ready_i), .aw_addr_i(aw_addr_i),
    .w_valid_i(w_valid_i), .w_ready_i(w_ready_i), .w_last_i(w_last_i),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .char_valid_o(char_valid_o), .char_data_o(char_data_o),
    .err_valid_o(err_valid_o), .err_count_o(err_count_o),
    .done_o(done_o), .exit_code_o(exit_code_o), .timeout_o(timeout_o),
    .overflow_o(overflow_o), .orphan_w_o(orphan_w_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: run phase derived from absolute cycle numbers, AW tracking as a queue.
  int          cyc = 0;
  int          m_s = 0;
  bit          m_active, m_done, m_to, m_cv, m_ev, m_ovf, m_orph, m_first;
  logic [31:0] m_boot, m_exit, m_err;
  logic [7:0]  m_char;
  logic [31:0] aq[$];
  bit          p_act, p_run, p_aw, p_w, p_pair, p_fromq, p_byp, p_eoc;
  logic [31:0] p_addr;

  function automatic logic [7:0] low_byte(logic [31:0] d, logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return d[8*i +: 8];
    return 8'h00;
  endfunction

  always @(posedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      m_active = 0; m_done = 0; m_to = 0; m_cv = 0; m_ev = 0; m_ovf = 0; m_orph = 0;
      m_first = 1; m_boot = 0; m_exit = 0; m_err = 0; m_char = 0;
      aq.delete();
    end else begin
      p_act = m_active && !m_done;
      p_run = p_act && (cyc - 1 >= m_s + INIT);
      p_aw = aw_valid_i && aw_ready_i;
      p_w  = w_valid_i && w_ready_i;
      p_pair = 0; p_fromq = 0; p_byp = 0; p_eoc = 0; p_addr = 0;
      m_cv = 0; m_ev = 0;
      if (p_w) begin
        if (aq.size() > 0) begin p_addr = aq[0]; p_pair = 1; p_fromq = 1; end
        else if (p_aw)     begin p_addr = aw_addr_i; p_pair = 1; p_byp = 1; end
        else m_orph = 1;
      end
      if (p_pair) begin
        if (m_first && p_act) begin
          if ((p_addr & ~32'd3) == A_OUT && w_strb_i != 0) begin
            m_cv = 1; m_char = low_byte(w_data_i, w_strb_i);
          end
          if ((p_addr & ~32'd3) == A_ERR) begin m_ev = 1; m_err = w_data_i; end
          if ((p_addr & ~32'd3) == A_EOC && p_run && w_data_i != 0) p_eoc = 1;
        end
        if (w_last_i && p_fromq) void'(aq.pop_front());
        m_first = w_last_i;
      end
      if (p_aw && !(p_byp && w_last_i)) begin
        if (aq.size() < DEPTH) aq.push_back(aw_addr_i);
        else m_ovf = 1;
      end
      if (p_eoc) begin
        m_done = 1; m_exit = w_data_i;
      end else if (p_run && cyc == m_s + INIT + TO) begin
        m_done = 1; m_to = 1; m_exit = 32'hFFFF_FFFF;
      end
      if (!m_active && start_i) begin m_active = 1; m_s = cyc; m_boot = boot_addr_i; end
    end
  end

  int n_pass = 0, n_total = 0;
  int t_start, guard, nchar;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("boot_addr", boot_addr_o, m_boot);
    chk("fetch_en", 32'(fetch_enable_o), 32'(m_active && !m_done && cyc >= m_s + INIT));
    chk("char_valid", 32'(char_valid_o), 32'(m_cv));
    chk("char_data", 32'(char_data_o), 32'(m_char));
    chk("err_valid", 32'(err_valid_o), 32'(m_ev));
    chk("err_count", err_count_o, m_err);
    chk("done", 32'(done_o), 32'(m_done));
    chk("exit_code", exit_code_o, m_exit);
    chk("timeout", 32'(timeout_o), 32'(m_to));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("orphan", 32'(orphan_w_o), 32'(m_orph));
  endtask

  task automatic step();
    @(negedge clk_i);
    check_all();
  endtask

  task automatic aw(logic [31:0] a);
    aw_valid_i = 1; aw_addr_i = a;
    step();
    aw_valid_i = 0;
  endtask

  task automatic wbeat(logic [31:0] d, logic [3:0] s, logic l);
    w_valid_i = 1; w_data_i = d; w_strb_i = s; w_last_i = l;
    step();
    w_valid_i = 0;
  endtask

  task automatic wait_fetch();
    guard = 0;
    while (!fetch_enable_o && guard < 400) begin step(); guard++; end
    chk("fetch_wait", 32'(fetch_enable_o), 32'd1);
  endtask

  task automatic do_start(logic [31:0] b);
    start_i = 1; boot_addr_i = b; t_start = cyc + 1;
    step();
    start_i = 0; boot_addr_i = $urandom;
  endtask

  task automatic rand_txn();
    logic [31:0] a;
    int len;
    len = $urandom_range(1, 3);
    case ($urandom_range(0, 4))
      0: a = A_OUT;
      1: a = A_ERR;
      2: a = A_EOC;
      3: a = 32'h2000_0000 | 32'($urandom_range(0, 255) << 2);
      default: a = A_OUT | 32'($urandom_range(0, 3));
    endcase
    if ($urandom_range(0, 1) == 1) begin
      aw_valid_i = 1; aw_addr_i = a;
    end else begin
      aw(a);
      repeat ($urandom_range(0, 2)) step();
    end
    for (int b = 0; b < len; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        w_valid_i = 1; w_ready_i = 0; w_data_i = $urandom; w_last_i = 0;
        step();
        aw_valid_i = 0; w_ready_i = 1;
      end
      w_valid_i = 1; w_data_i = $urandom; w_strb_i = 4'($urandom_range(0, 15));
      w_last_i = (b == len - 1);
      step();
      aw_valid_i = 0; w_valid_i = 0;
    end
  endtask

  initial begin
    rst_ni = 0; start_i = 0; boot_addr_i = 32'hDEAD_BEEF;
    aw_valid_i = 0; aw_ready_i = 1; aw_addr_i = 0;
    w_valid_i = 0; w_ready_i = 1; w_last_i = 0; w_data_i = 0; w_strb_i = 0;
    step(); step();
    chk("rst_boot", boot_addr_o, 32'd0);
    chk("rst_fetch", 32'(fetch_enable_o), 32'd0);
    chk("rst_exit", exit_code_o, 32'd0);
    chk("rst_err", err_count_o, 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    rst_ni = 1;
    step();

    // Boot and print decode during INIT
    do_start(32'h1C00_0080);
    chk("boot_latch", boot_addr_o, 32'h1C00_0080);
    aw(A_OUT); step(); step();
    wbeat(32'h0000_0048, 4'b0001, 1);
    chk("print1_v", 32'(char_valid_o), 32'd1);
    chk("print1_c", 32'(char_data_o), 32'h48);
    step();
    chk("print1_pulse", 32'(char_valid_o), 32'd0);
    aw(A_OUT); step(); step();
    wbeat(32'h0041_0000, 4'b0100, 1);
    chk("print2_c", 32'(char_data_o), 32'h41);

    // Three outstanding AWs, then W beats in order
    aw(A_OUT); aw(32'h2000_0000); aw(A_ERR);
    nchar = 0;
    wbeat(32'h0000_0043, 4'b1111, 1); nchar += int'(char_valid_o);
    for (int i = 0; i < 4; i++) begin
      wbeat(32'h5858_5858, 4'b1111, i == 3); nchar += int'(char_valid_o);
    end
    wbeat(32'h0000_1234, 4'b1111, 1); nchar += int'(char_valid_o);
    chk("reorder_chars", 32'(nchar), 32'd1);
    chk("reorder_err", err_count_o, 32'h0000_1234);
    chk("reorder_errv", 32'(err_valid_o), 32'd1);

    repeat (10) rand_txn();

    wait_fetch();
    chk("fetch_latency", 32'(cyc - t_start), 32'(INIT));

    // EOC of zero does not end the run; nonzero does
    aw(A_EOC); wbeat(32'd0, 4'b1111, 1);
    chk("eoc0_done", 32'(done_o), 32'd0);
    aw(A_EOC); wbeat(32'd7, 4'b1111, 1);
    chk("eoc_done", 32'(done_o), 32'd1);
    chk("eoc_exit", exit_code_o, 32'd7);
    chk("eoc_fetch", 32'(fetch_enable_o), 32'd0);
    start_i = 1; step(); start_i = 0;
    chk("done_ignore_start", 32'(fetch_enable_o), 32'd0);

    // AW FIFO overflow
    repeat (DEPTH) aw(32'h2000_0000);
    chk("ovf_not_yet", 32'(overflow_o), 32'd0);
    aw(32'h2000_0040);
    chk("ovf_set", 32'(overflow_o), 32'd1);

    rst_ni = 0; step(); rst_ni = 1;
    chk("rst2_ovf", 32'(overflow_o), 32'd0);
    wbeat(32'h0000_0055, 4'b0001, 1);
    chk("orphan_set", 32'(orphan_w_o), 32'd1);

    // Bypass: AW and W in the same cycle with an empty FIFO
    rst_ni = 0; step(); rst_ni = 1; step();
    do_start($urandom);
    aw_valid_i = 1; aw_addr_i = A_OUT;
    wbeat(32'h0000_005A, 4'b0001, 1);
    aw_valid_i = 0;
    chk("bypass_v", 32'(char_valid_o), 32'd1);
    chk("bypass_c", 32'(char_data_o), 32'h5A);
    wbeat(32'h0000_0061, 4'b0001, 1);
    chk("bypass_nopush", 32'(orphan_w_o), 32'd1);
    repeat (6) rand_txn();

    // Reset in the middle of RUN
    wait_fetch();
    repeat (5) step();
    rst_ni = 0; step(); rst_ni = 1;
    chk("midrst_fetch", 32'(fetch_enable_o), 32'd0);
    chk("midrst_boot", boot_addr_o, 32'd0);
    chk("midrst_orphan", 32'(orphan_w_o), 32'd0);

    // Timeout run
    do_start(32'h1C00_1000);
    wait_fetch();
    chk("fetch_latency2", 32'(cyc - t_start), 32'(INIT));
    for (int k = 1; k <= TO; k++) begin
      step();
      if (k == TO - 1) chk("to_early", 32'(timeout_o), 32'd0);
    end
    chk("to_flag", 32'(timeout_o), 32'd1);
    chk("to_exit", exit_code_o, 32'hFFFF_FFFF);
    chk("to_fetch", 32'(fetch_enable_o), 32'd0);

    // EOC landing on the timeout cycle wins
    rst_ni = 0; step(); rst_ni = 1; step();
    do_start(32'h1C00_2000);
    wait_fetch();
    repeat (TO - 1) step();
    aw_valid_i = 1; aw_addr_i = A_EOC;
    wbeat(32'd9, 4'b1111, 1);
    aw_valid_i = 0;
    chk("eoc_vs_to_exit", exit_code_o, 32'd9);
    chk("eoc_vs_to_flag", 32'(timeout_o), 32'd0);
    chk("eoc_vs_to_done", 32'(done_o), 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
